// File: rtl/darkbus_router.sv
// darkbus_router: one provider to NSLV consumers, address-decoded.
// Single outstanding request, registered completion and timeout.
module darkbus_router #(
  parameter int NSLV = 4,
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int SELW = 4,
  parameter int TMO  = 255
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              M_EN,
  input  logic              M_RW,
  input  logic [DW/8-1:0]   M_BE,
  input  logic [AW-1:0]     M_ADDR,
  input  logic [DW-1:0]     M_WDATA,
  output logic [DW-1:0]     M_RDATA,
  output logic              M_VALID,
  output logic              M_ERR,
  output logic [NSLV-1:0]   S_EN,
  output logic              S_RW,
  output logic [DW/8-1:0]   S_BE,
  output logic [AW-1:0]     S_ADDR,
  output logic [DW-1:0]     S_WDATA,
  input  logic [NSLV*DW-1:0] S_RDATA,
  input  logic [NSLV-1:0]   S_VALID
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int NP = 2 ** SELW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      r_state;
  logic [SELW-1:0] r_sel;
  logic [CW-1:0]   r_cnt;
  logic [NSLV-1:0] r_sen;
  logic            r_rw;
  logic [DW/8-1:0] r_be;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_valid;
  logic            r_err;

  logic [SELW-1:0] w_sel;
  logic            w_map;
  logic [NSLV-1:0] w_onehot;
  logic [NP-1:0]   w_svp;
  logic            w_hit;
  logic [DW-1:0]   w_rd;
  logic            w_tmo;

  assign w_sel = M_ADDR[AW-1 -: SELW];
  assign w_map = 32'(w_sel) < NSLV;
  assign w_hit = w_svp[r_sel];
  assign w_tmo = (TMO != 0) && (r_cnt == CW'(TMO - 1));

  // Decode request port and mux the selected consumer's response.
  always_comb begin
    w_onehot = '0;
    w_svp    = '0;
    w_rd     = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_onehot[i] = (w_sel == SELW'(i));
      w_svp[i]    = S_VALID[i];
      if (r_sel == SELW'(i))
        w_rd = S_RDATA[i*DW +: DW];
    end
  end

  // Transaction FSM: latch request, wait for consumer or timeout, pulse.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_sen   <= '0;
      r_rw    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (M_EN) begin
            r_rw    <= M_RW;
            r_be    <= M_BE;
            r_addr  <= M_ADDR;
            r_wdata <= M_WDATA;
            r_sel   <= w_sel;
            r_cnt   <= '0;
            if (w_map) begin
              r_sen   <= w_onehot;
              r_state <= BUSY;
            end else begin
              r_rdata <= '0;
              r_valid <= 1'b1;
              r_err   <= 1'b1;
              r_state <= RESP;
            end
          end
        end
        BUSY: begin
          if (w_hit) begin
            r_sen   <= '0;
            r_rdata <= r_rw ? '0 : w_rd;
            r_valid <= 1'b1;
            r_state <= RESP;
          end else if (w_tmo) begin
            r_sen   <= '0;
            r_rdata <= '0;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (TMO != 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign M_RDATA = r_rdata;
  assign M_VALID = r_valid;
  assign M_ERR   = r_err;
  assign S_EN    = r_sen;
  assign S_RW    = r_rw;
  assign S_BE    = r_be;
  assign S_ADDR  = r_addr;
  assign S_WDATA = r_wdata;

endmodule

// File: doc/darkbus_router.md
DARKBUS_ROUTER -- requirements
Module: darkbus_router

Interface
Parameters:
REQ-001 The block SHALL take parameter NSLV, default 4: number of consumer ports, 1..16.
REQ-002 The block SHALL take parameter DW, default 32: data width, a multiple of 8.
REQ-003 The block SHALL take parameter AW, default 32: address width.
REQ-004 The block SHALL take parameter SELW, default 4: the port index is taken from M_ADDR[AW-1 -: SELW], and 2**SELW SHALL be at least NSLV.
REQ-005 The block SHALL take parameter TMO, default 255: timeout in cycles, where 0 disables the timeout.

Ports:
REQ-006 The block SHALL have CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have RES, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have M_EN, input, 1 bit: provider request, held until M_VALID.
REQ-009 The block SHALL have M_RW, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have M_BE, input, DW/8 bits: byte enables.
REQ-011 The block SHALL have M_ADDR, input, AW bits: address.
REQ-012 The block SHALL have M_WDATA, input, DW bits: write data.
REQ-013 The block SHALL have M_RDATA, output, DW bits: read data, registered.
REQ-014 The block SHALL have M_VALID, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have M_ERR, output, 1 bit: error qualifier, valid only with M_VALID.
REQ-016 The block SHALL have S_EN, output, NSLV bits: per-consumer request, one-hot or zero.
REQ-017 The block SHALL have S_RW, S_BE, S_ADDR and S_WDATA, outputs, of 1, DW/8, AW and DW bits: latched request fields shared by all consumers.
REQ-018 The block SHALL have S_RDATA, input, NSLV*DW bits: consumer i drives slice [i*DW +: DW].
REQ-019 The block SHALL have S_VALID, input, NSLV bits: per-consumer completion.

Function
REQ-020 The block SHALL implement the states IDLE, BUSY and RESP.
REQ-021 In IDLE with M_EN=1, the block SHALL latch M_RW, M_BE, M_ADDR and M_WDATA into the S_* registers and compute sel = M_ADDR[AW-1 -: SELW].
REQ-022 From IDLE with sel < NSLV, the block SHALL go to BUSY, with S_EN[sel]=1 from the next cycle and the timeout counter cleared.
REQ-023 From IDLE with sel >= NSLV, the block SHALL go directly to RESP with M_ERR=1 and M_RDATA=0, asserting no S_EN bit.
REQ-024 In BUSY, S_EN[sel] SHALL stay high and all S_* fields SHALL stay stable.
REQ-025 In BUSY, only S_VALID[sel] SHALL be observed; S_VALID bits of other ports SHALL be ignored.
REQ-026 In BUSY with S_VALID[sel]=1, the block SHALL go to RESP and drop S_EN on the next edge.
REQ-027 On that completion, M_RDATA SHALL take S_RDATA slice sel for reads and 0 for writes, with M_ERR=0.
REQ-028 In BUSY with TMO>0, the counter SHALL increment each cycle without S_VALID[sel].
REQ-029 When the counter reaches TMO-1 with S_VALID[sel]=0, the block SHALL go to RESP with M_ERR=1, M_RDATA=0 and S_EN=0.
REQ-030 If S_VALID[sel] arrives on the same cycle as the timeout, the completion SHALL win, giving M_ERR=0.
REQ-031 The counter width SHALL be $clog2(TMO+1), and it SHALL never wrap.
REQ-032 In RESP, M_VALID SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-033 M_EN SHALL be ignored in BUSY and RESP.
REQ-034 An M_EN still high in the IDLE cycle after RESP SHALL be a new transaction, giving back-to-back operation.
REQ-035 Latency with a zero-wait consumer (S_VALID high on the first S_EN cycle) SHALL be M_EN sampled at cycle 0, S_EN at cycle 1 and M_VALID at cycle 2.
REQ-036 Each added wait cycle SHALL add exactly one cycle of latency.
REQ-037 Minimum throughput SHALL be one transaction per 3 cycles.
REQ-038 M_RDATA SHALL hold its value outside the M_VALID cycle.
REQ-039 M_ERR SHALL be 0 whenever M_VALID=0.

Reset
REQ-040 While RES=1 the block SHALL be in IDLE, and all outputs (M_RDATA, M_VALID, M_ERR, S_EN, S_RW, S_BE, S_ADDR, S_WDATA) and the counter SHALL be 0, asynchronously.
REQ-041 A reset during BUSY or RESP SHALL drop S_EN and M_VALID immediately and produce no completion pulse.
REQ-042 On the first edge after RES falls, the block SHALL be able to accept a request.

Verification
REQ-043 Zero-wait read, defaults: M_ADDR=0x2000_0010, M_RW=0; port 2 returns 0xCAFEBABE immediately -> S_EN=4'b0100 at cycle 1, M_VALID=1, M_RDATA=0xCAFEBABE, M_ERR=0 at cycle 2.
REQ-044 Write with 3 wait cycles to port 1: M_WDATA=0x12345678, M_BE=4'b0011 -> S_WDATA and S_BE stable for 4 cycles, M_VALID at cycle 5, M_RDATA=0.
REQ-045 Unmapped access, M_ADDR=0x7000_0000 with NSLV=4 -> S_EN stays 0, M_VALID=1 and M_ERR=1 at cycle 1, M_RDATA=0.
REQ-046 Timeout, TMO=8, port 0 never responds -> S_EN[0] high 8 cycles, then M_VALID=1, M_ERR=1; S_VALID[0] asserted on the 8th cycle instead -> M_ERR=0.
REQ-047 Reset and filtering: RES pulsed during BUSY -> S_EN=0 asynchronously and no M_VALID; S_VALID[3] while port 1 is selected -> ignored.
REQ-048 Back-to-back: M_EN held high across two reads to ports 0 then 3 -> two M_VALID pulses 3 cycles apart, each with the correct data.
